// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered square wave CLK_DIV of period N plus a one-cycle TICK enable.
// Define CLKDIV_LOCK_EN for glitch-free divisor updates at the period boundary; otherwise writes apply immediately.
module clk_div_prog #(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [CNT_W-1:0] DIV_IN,
  input  logic             DIV_WR,
  output logic             CLK_DIV,
  output logic             TICK,
  output logic             BUSY
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);
  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);

  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] div_clamp;
  logic [CNT_W:0]   half;
  logic             wrap;
  logic             clk_div_next;
  logic             tick_next;

  always_comb begin
    div_clamp    = (DIV_IN < DIV_MIN) ? DIV_MIN : DIV_IN;
    wrap         = (cnt_reg == div_reg - 1'b1);
    cnt_next     = wrap ? '0 : cnt_reg + 1'b1;
    // Extra bit keeps N = 2^CNT_W-1 from overflowing in N+1.
    half         = ({1'b0, div_reg} + 1'b1) >> 1;
    clk_div_next = ({1'b0, cnt_next} < half);
    tick_next    = (cnt_next == '0);
  end

`ifdef CLKDIV_LOCK_EN
  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] pend_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (DIV_WR) state_next = PEND;
      PEND:    if (!DIV_WR && EN && wrap) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= RUN;
      pend_reg  <= DIV_INIT;
      div_reg   <= DIV_INIT;
      cnt_reg   <= '0;
      CLK_DIV   <= 1'b0;
      TICK      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (DIV_WR) pend_reg <= div_clamp;
      if (EN) begin
        cnt_reg <= cnt_next;
        CLK_DIV <= clk_div_next;
        TICK    <= tick_next;
        // The wrap consumes the value pending before this edge; a same-edge write stays pending.
        if (wrap && state_reg == PEND) div_reg <= pend_reg;
      end else begin
        TICK <= 1'b0;
      end
    end
  end

  assign BUSY = (state_reg == PEND);
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_reg <= DIV_INIT;
      cnt_reg <= '0;
      CLK_DIV <= 1'b0;
      TICK    <= 1'b0;
    end else if (DIV_WR) begin
      div_reg <= div_clamp;
      cnt_reg <= '0;
      CLK_DIV <= 1'b0;
      TICK    <= 1'b0;
    end else if (EN) begin
      cnt_reg <= cnt_next;
      CLK_DIV <= clk_div_next;
      TICK    <= tick_next;
    end else begin
      TICK <= 1'b0;
    end
  end

  assign BUSY = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog; expectations follow CLKDIV_LOCK_EN when it is defined.
module tb_clk_div_prog;

  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b1;
  logic [CNT_W-1:0] DIV_IN = '0;
  logic             DIV_WR = 1'b0;
  logic             CLK_DIV;
  logic             TICK;
  logic             BUSY;

  int compared = 0;
  int mismatched = 0;

  clk_div_prog #(.CNT_W(CNT_W), .DIV_RESET(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIV_IN(DIV_IN), .DIV_WR(DIV_WR),
    .CLK_DIV(CLK_DIV), .TICK(TICK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic c, input logic t, input logic b);
    compared++;
    assert (CLK_DIV === c) else begin
      mismatched++;
      $error("FAIL %s CLK_DIV: got %b expected %b", tag, CLK_DIV, c);
    end
    compared++;
    assert (TICK === t) else begin
      mismatched++;
      $error("FAIL %s TICK: got %b expected %b", tag, TICK, t);
    end
    compared++;
    assert (BUSY === b) else begin
      mismatched++;
      $error("FAIL %s BUSY: got %b expected %b", tag, BUSY, b);
    end
  endtask

  task automatic step(input string tag, input logic c, input logic t, input logic b);
    @(posedge CLK); #1;
    chk(tag, c, t, b);
    $display("step %s: CLK_DIV=%b TICK=%b BUSY=%b", tag, CLK_DIV, TICK, BUSY);
  endtask

  task automatic wr_step(input string tag, input logic [CNT_W-1:0] n,
                         input logic c, input logic t, input logic b);
    DIV_IN = n;
    DIV_WR = 1'b1;
    @(posedge CLK); #1;
    DIV_WR = 1'b0;
    chk(tag, c, t, b);
    $display("write %s DIV_IN=%0d: CLK_DIV=%b TICK=%b BUSY=%b", tag, n, CLK_DIV, TICK, BUSY);
  endtask

  task automatic seq(input string tag, input string cs, input string ts, input logic b);
    for (int i = 0; i < cs.len(); i++) begin
      @(posedge CLK); #1;
      chk($sformatf("%s[%0d]", tag, i), cs[i] == 8'h31, ts[i] == 8'h31, b);
    end
    $display("seq %s: %0d edges, CLK_DIV=%s TICK=%s", tag, cs.len(), cs, ts);
  endtask

  initial begin
    #2;
    chk("reset_state", 1'b0, 1'b0, 1'b0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;

    seq("rst_n4", "1001100110011001", "0001000100010001", 1'b0);

`ifdef CLKDIV_LOCK_EN
    wr_step("n5", 8'd5, 1'b1, 1'b0, 1'b1);
    seq("n5_old", "00", "00", 1'b1);
    step("n5_wrap", 1'b1, 1'b1, 1'b0);
`else
    wr_step("n5", 8'd5, 1'b0, 1'b0, 1'b0);
`endif
    seq("n5", "1100111001", "0000100001", 1'b0);

`ifdef CLKDIV_LOCK_EN
    wr_step("n0", 8'd0, 1'b1, 1'b0, 1'b1);
    seq("n0_old", "100", "000", 1'b1);
    step("n0_wrap", 1'b1, 1'b1, 1'b0);
`else
    wr_step("n0", 8'd0, 1'b0, 1'b0, 1'b0);
`endif
    seq("n0", "0101", "0101", 1'b0);

`ifdef CLKDIV_LOCK_EN
    wr_step("n1", 8'd1, 1'b0, 1'b0, 1'b1);
    step("n1_wrap", 1'b1, 1'b1, 1'b0);
`else
    wr_step("n1", 8'd1, 1'b0, 1'b0, 1'b0);
`endif
    seq("n1", "0101", "0101", 1'b0);

`ifdef CLKDIV_LOCK_EN
    wr_step("n8", 8'd8, 1'b0, 1'b0, 1'b1);
    step("n8_wrap", 1'b1, 1'b1, 1'b0);
`else
    wr_step("n8", 8'd8, 1'b0, 1'b0, 1'b0);
`endif
    seq("n8_pre", "111", "000", 1'b0);
    EN = 1'b0;
    seq("en_off_hi", "1111111", "0000000", 1'b0);
    EN = 1'b1;
    seq("en_resume", "00001", "00001", 1'b0);
    EN = 1'b0;
    seq("en_off_tick", "11", "00", 1'b0);
    EN = 1'b1;
    seq("en_resume2", "11100001", "00000001", 1'b0);

    seq("n8_to5", "11100", "00000", 1'b0);
`ifdef CLKDIV_LOCK_EN
    wr_step("n3_at5", 8'd3, 1'b0, 1'b0, 1'b1);
    step("n3_old", 1'b0, 1'b0, 1'b1);
    step("n3_wrap", 1'b1, 1'b1, 1'b0);
`else
    wr_step("n3_at5", 8'd3, 1'b0, 1'b0, 1'b0);
`endif
    seq("n3", "101101", "001001", 1'b0);

`ifdef CLKDIV_LOCK_EN
    wr_step("b2b_6", 8'd6, 1'b1, 1'b0, 1'b1);
    wr_step("b2b_10", 8'd10, 1'b0, 1'b0, 1'b1);
    step("b2b_wrap", 1'b1, 1'b1, 1'b0);
`else
    wr_step("b2b_6", 8'd6, 1'b0, 1'b0, 1'b0);
    wr_step("b2b_10", 8'd10, 1'b0, 1'b0, 1'b0);
`endif
    seq("n10", "1111000001", "0000000001", 1'b0);

`ifdef CLKDIV_LOCK_EN
    wr_step("pend7", 8'd7, 1'b1, 1'b0, 1'b1);
`else
    step("pre_rst", 1'b1, 1'b0, 1'b0);
`endif
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst", 1'b0, 1'b0, 1'b0);
    $display("async reset mid-cycle: CLK_DIV=%b TICK=%b BUSY=%b", CLK_DIV, TICK, BUSY);
    #1;
    RST = 1'b0;
    seq("post_rst_n4", "10011001", "00010001", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
